// File: rtl/boolean_sweep.sv
// -----------------------------------------------------------------------------
// boolean_sweep
//   Stimulus/capture sequencer for a 3-input combinational boolean function.
//   On an accepted start it drives {a,b,c} = 0..7, holding each vector for
//   DWELL cycles, samples f_in on the last cycle of each dwell and assembles
//   the samples into an 8-bit truth table (truth[i] = F at {a,b,c} = i).
//   Completion is marked by a single-cycle done pulse and truth_valid.
//
// Parameters
//   DWELL : cycles each vector is held (1..255)
//   CNT_W : dwell counter width, 2**CNT_W > DWELL
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : sweep request, honoured only in IDLE or DONE
//   abort       : synchronous sweep cancel (wins over start)
//   f_in        : F output of the combinational function
//   a, b, c     : vector to the function (a = MSB)
//   busy        : sweep in progress
//   done        : one-cycle completion pulse
//   truth       : captured truth table
//   truth_valid : truth holds a complete, unaborted sweep
//
// Optional build macro BOOLEAN_SWEEP_CHECK_EN adds:
//   expected    : reference table, sampled in the DONE cycle
//   mismatch    : truth != expected, shown in DONE and held afterwards
//   first_bad   : lowest differing index (0 if none)
// -----------------------------------------------------------------------------
module boolean_sweep #(
  parameter int unsigned DWELL = 10,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       f_in,
`ifdef BOOLEAN_SWEEP_CHECK_EN
  input  logic [7:0] expected,
  output logic       mismatch,
  output logic [2:0] first_bad,
`endif
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth,
  output logic       truth_valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         truth_q, truth_d;
  logic               valid_q, valid_d;
  logic               start_ok;
  logic               last_dwell;

  // abort suppresses a same-cycle start in every state
  assign start_ok   = start && !abort && (state_q != ST_DRIVE);
  assign last_dwell = (cnt_q == CNT_W'(DWELL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      truth_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      truth_q <= truth_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    truth_d = truth_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          truth_d = '0;
          valid_d = 1'b0;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      ST_DRIVE: begin
        if (abort) begin
          // partial truth bits are deliberately kept
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
        end else if (last_dwell) begin
          truth_d[idx_q] = f_in;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
            state_d = ST_DONE;
            idx_d   = '0;
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode from registered state only, so the vector is glitch-free
  // and returns to 0 outside DRIVE.
  always_comb begin
    busy        = (state_q == ST_DRIVE);
    done        = (state_q == ST_DONE);
    {a, b, c}   = (state_q == ST_DRIVE) ? idx_q : 3'd0;
    truth       = truth_q;
    truth_valid = valid_q;
  end

`ifdef BOOLEAN_SWEEP_CHECK_EN
  logic [7:0] diff;
  logic       mismatch_now;
  logic [2:0] first_bad_now;
  logic       found;
  logic       mismatch_q;
  logic [2:0] first_bad_q;

  always_comb begin
    diff          = truth_q ^ expected;
    mismatch_now  = |diff;
    first_bad_now = 3'd0;
    found         = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (diff[i] && !found) begin
        first_bad_now = 3'(i);
        found         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q  <= 1'b0;
      first_bad_q <= '0;
    end else if (start_ok) begin
      mismatch_q  <= 1'b0;
      first_bad_q <= '0;
    end else if (state_q == ST_DONE) begin
      mismatch_q  <= mismatch_now;
      first_bad_q <= first_bad_now;
    end
  end

  // The compare result is visible combinationally in the DONE cycle itself
  // and held by the registers after it.
  always_comb begin
    mismatch  = (state_q == ST_DONE) ? mismatch_now  : mismatch_q;
    first_bad = (state_q == ST_DONE) ? first_bad_now : first_bad_q;
  end
`endif

endmodule

// File: tb/tb_boolean_sweep.sv
module tb_boolean_sweep;

  localparam int DW0 = 10;
  localparam int DW1 = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_v [2];
  logic       abort_v [2];
  logic       f_v     [2];
  logic       a_v     [2];
  logic       b_v     [2];
  logic       c_v     [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic       tv_v    [2];
  logic [7:0] truth_v [2];
  logic [7:0] ftab_v  [2];
`ifdef BOOLEAN_SWEEP_CHECK_EN
  logic [7:0] exp_v   [2];
  logic       mm_v    [2];
  logic [2:0] fb_v    [2];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    // function under test modelled as a lookup of the current vector
    assign f_v[g] = ftab_v[g][{a_v[g], b_v[g], c_v[g]}];

    boolean_sweep #(
      .DWELL((g == 0) ? DW0 : DW1),
      .CNT_W(8)
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_v[g]),
      .abort       (abort_v[g]),
      .f_in        (f_v[g]),
`ifdef BOOLEAN_SWEEP_CHECK_EN
      .expected    (exp_v[g]),
      .mismatch    (mm_v[g]),
      .first_bad   (fb_v[g]),
`endif
      .a           (a_v[g]),
      .b           (b_v[g]),
      .c           (c_v[g]),
      .busy        (busy_v[g]),
      .done        (done_v[g]),
      .truth       (truth_v[g]),
      .truth_valid (tv_v[g])
    );
  end

  function automatic int dw_of(input int u);
    return (u == 0) ? DW0 : DW1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int u);
    @(posedge clk); #1 start_v[u] = 1'b1;
    @(posedge clk); #1 start_v[u] = 1'b0;
  endtask

  // One full sweep; cycle k is the k-th cycle after the accepting edge.
  task automatic sweep(input int u, input logic [7:0] tab, input bit noise, input string tag);
    int dw      = dw_of(u);
    int done_at = 0;
    int busy_n  = 0;
    int abc_err = 0;
    logic [2:0] exp_abc;
    ftab_v[u] = tab;
    pulse_start(u);
    for (int k = 1; k <= 8 * dw + 4 && done_at == 0; k++) begin
      @(negedge clk);
      if (busy_v[u]) busy_n++;
      exp_abc = (k <= 8 * dw) ? 3'((k - 1) / dw) : 3'd0;
      if ({a_v[u], b_v[u], c_v[u]} != exp_abc) abc_err++;
      if (done_v[u]) done_at = k;
      if (noise) start_v[u] = (k <= 8 * dw) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start_v[u] = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_at), 32'(8 * dw + 1));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(8 * dw));
    check({tag, "_abc_seq_errs"}, 32'(abc_err), 32'd0);
    check({tag, "_truth"}, 32'(truth_v[u]), 32'(tab));
    check({tag, "_truth_valid"}, 32'(tv_v[u]), 32'd1);
`ifdef BOOLEAN_SWEEP_CHECK_EN
    begin
      logic [7:0] d;
      logic [2:0] fb;
      d  = tab ^ exp_v[u];
      fb = 3'd0;
      for (int i = 7; i >= 0; i--) if (d[i]) fb = 3'(i);
      check({tag, "_mismatch"}, 32'(mm_v[u]), 32'(d != 8'd0));
      check({tag, "_first_bad"}, 32'(fb_v[u]), 32'(fb));
    end
`endif
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'({done_v[u], tv_v[u]}), 32'(2'b01));
  endtask

  task automatic abort_test();
    int dw = dw_of(0);
    int dn = 0;
    logic [7:0] tab;
    tab = 8'($urandom);
    ftab_v[0] = tab;
    pulse_start(0);
    // third cycle of vector 4
    for (int k = 1; k <= 4 * dw + 3; k++) @(negedge clk);
    abort_v[0] = 1'b1;
    @(posedge clk); #1 abort_v[0] = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    check("abort_abc", 32'({a_v[0], b_v[0], c_v[0]}), 32'd0);
    check("abort_truth_valid", 32'(tv_v[0]), 32'd0);
    check("abort_partial_truth", 32'(truth_v[0]), 32'({4'b0, tab[3:0]}));
    for (int k = 0; k < 8 * dw; k++) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    // abort and start together while idle
    @(posedge clk); #1 start_v[0] = 1'b1; abort_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0; abort_v[0] = 1'b0;
    @(negedge clk);
    check("abort_beats_start", 32'(busy_v[0]), 32'd0);
  endtask

  task automatic reset_test();
    int dw = dw_of(0);
    logic [7:0] tab;
    tab = 8'($urandom) | 8'h01;
    ftab_v[0] = tab;
    pulse_start(0);
    for (int k = 1; k <= 5 * dw + 5; k++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("async_rst_ctl_u%0d", u),
            32'({busy_v[u], done_v[u], a_v[u], b_v[u], c_v[u], tv_v[u]}), 32'd0);
      check($sformatf("async_rst_truth_u%0d", u), 32'(truth_v[u]), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_needs_start", 32'(busy_v[0]), 32'd0);
    sweep(0, 8'($urandom), 1'b0, "u0_after_rst");
  endtask

  task automatic b2b(input int u);
    int dw = dw_of(u);
    int per = 8 * dw + 1;
    int seen [$];
    logic [7:0] tab;
    tab = 8'($urandom);
    ftab_v[u] = tab;
    @(posedge clk); #1 start_v[u] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 3 * per; k++) begin
      @(negedge clk);
      if (done_v[u]) seen.push_back(k);
    end
    start_v[u] = 1'b0;
    check($sformatf("b2b_u%0d_done_count", u), 32'(seen.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b_u%0d_done_%0d", u, i),
            32'((seen.size() > i) ? seen[i] : -1), 32'((i + 1) * per));
    check($sformatf("b2b_u%0d_truth", u), 32'(truth_v[u]), 32'(tab));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start_v[u] = 1'b0;
      abort_v[u] = 1'b0;
      ftab_v[u]  = 8'h00;
`ifdef BOOLEAN_SWEEP_CHECK_EN
      exp_v[u]   = 8'h00;
`endif
    end
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("reset_ctl_u%0d", u),
            32'({busy_v[u], done_v[u], a_v[u], b_v[u], c_v[u], tv_v[u]}), 32'd0);
      check($sformatf("reset_truth_u%0d", u), 32'(truth_v[u]), 32'd0);
    end
    #11 rst_n = 1'b1;

    sweep(0, 8'hEA, 1'b0, "u0_ab_or_c");
    sweep(1, 8'h96, 1'b0, "u1_xor");
    for (int i = 0; i < 3; i++) begin
      sweep(0, 8'($urandom), 1'(i), "u0_rand");
      sweep(1, 8'($urandom), 1'b1, "u1_rand");
    end
    abort_test();
    reset_test();
    b2b(0);
    b2b(1);
`ifdef BOOLEAN_SWEEP_CHECK_EN
    exp_v[0] = 8'h81;
    sweep(0, 8'h80, 1'b0, "chk_and3_mis");
    exp_v[0] = 8'h80;
    sweep(0, 8'h80, 1'b0, "chk_and3_match");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
